softmax_div_ctrl: RTL and testbench

Sequencer that drives the softmax normalisation divider (`proab_calu`, fixed-latency floating-point divide). On `start` it streams `len` exponentiated values from the intermediate memory into the divider's `data_in`, with the latched denominator on `sum`. It tracks in-flight operations with a latency-matched valid pipeline and writes each quotient to the output memory at the same index it was read from. It is the issuing and collecting end of the divider interface and sits between the intermediate buffer and the softmax output buffer.

---
 rtl/softmax_pkg.sv | 15 +
 rtl/lat_valid_pipe.sv | 24 ++
 rtl/softmax_div_ctrl.sv | 134 +++++++++++++
 tb/tb_softmax_div_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax normalisation divider path.
package softmax_pkg;

  // Sequencer states for the divide controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Divider latency shared with proab_calu so both ends stay matched.
  localparam int SOFTMAX_DIV_LAT = 14;

endpackage

// File: rtl/lat_valid_pipe.sv
// Resettable 1-bit shift register that tracks in-flight operations.
module lat_valid_pipe #(
  parameter int DEPTH = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic pop
);

  logic [DEPTH-1:0] stage;

  // Shift the valid token one stage per cycle; reset drops all tokens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], push};
    end
  end

  assign pop = stage[DEPTH-1];

endmodule

// File: rtl/softmax_div_ctrl.sv
// Streams intermediate values through the fixed-latency divider and writes
// each quotient back at the index it was read from.
module softmax_div_ctrl
  import softmax_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int DIV_LAT = SOFTMAX_DIV_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] sum_in,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  input  logic [DW-1:0] div_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  state_t        state;
  logic [AW-1:0] len_reg;
  logic [DW-1:0] sum_reg;
  logic [AW-1:0] wr_cnt;
  logic          rd_en_d;
  logic          pop;
  logic          job_start;

  assign job_start = (state == IDLE) && start;

  // Control FSM; rd_addr doubles as the read counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      len_reg <= '0;
      sum_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_reg <= len;
            sum_reg <= sum_in;
            busy    <= 1'b1;
            rd_addr <= '0;
            if (len == '0) begin
              rd_en <= 1'b0;
              state <= DONE;
            end else begin
              rd_en <= 1'b1;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (rd_addr == len_reg - AW'(1)) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        DRAIN: begin
          // wr_cnt reaches len on the edge that issues the last write.
          if (wr_cnt == len_reg) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // An empty job enters with done low and raises it first, so
          // done always lands one cycle after the DONE entry decision.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and collect stages around the divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_en_d <= 1'b0;
      div_a   <= '0;
      div_b   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
    end else begin
      rd_en_d <= rd_en;
      if (rd_en_d) begin
        div_a <= rd_data;
        div_b <= sum_reg;
      end
      wr_en <= pop;
      if (pop) begin
        wr_data <= div_result;
        wr_addr <= wr_cnt;
        wr_cnt  <= wr_cnt + AW'(1);
      end else if (job_start) begin
        wr_cnt <= '0;
      end
    end
  end

  // Token enters with the operands and exits when the quotient is ready.
  lat_valid_pipe #(
    .DEPTH(DIV_LAT + 1)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .push(rd_en_d),
    .pop (pop)
  );

endmodule

// File: tb/tb_softmax_div_ctrl.sv
// Scoreboard bench for softmax_div_ctrl with memory and divider models.
module tb_softmax_div_ctrl;
  import softmax_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int LAT = SOFTMAX_DIV_LAT;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] sum_in = '0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, div_a, div_b, div_result, wr_data;

  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] dpipe [LAT];

  ev_t         rdq[$];
  ev_t         wrq[$];
  int          doneq[$];
  logic [31:0] dir_exp[$];

  int cyc = 0;
  int busy_first = 1;
  int busy_last = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  softmax_div_ctrl #(.DW(DW), .AW(AW), .DIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .sum_in(sum_in),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  // Single-precision <-> real helpers (normals only; tiny values flush to 0).
  function automatic real sp2real(input logic [31:0] b);
    logic [10:0] e;
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int          se;
    d  = $realtobits(r);
    se = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0 || se <= 0) return {d[63], 31'd0};
    if (se >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], se[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(a) / sp2real(b));
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f[31]    = 1'($urandom_range(0, 1));
    f[30:23] = 8'($urandom_range(100, 150));
    f[22:0]  = 23'($urandom);
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Intermediate memory: registered read.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Divider model: fixed latency, never reset.
  always @(posedge clk) begin
    dpipe[0] <= fdiv(div_a, div_b);
    for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign div_result = dpipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected events whenever the DUT presents them.
  always @(negedge clk) begin
    ev_t e;
    if (rd_en === 1'b1) begin
      if (rdq.size() == 0) chk("unexpected_rd", 64'(rd_addr), 64'hDEAD);
      else begin
        e = rdq.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(e.cyc));
        chk("rd_addr", 64'(rd_addr), 64'(e.addr));
      end
    end
    if (wr_en === 1'b1) begin
      if (wrq.size() == 0) chk("unexpected_wr", 64'(wr_addr), 64'hDEAD);
      else begin
        e = wrq.pop_front();
        $display("wr cycle %0d addr %0d data %08h", cyc, wr_addr, wr_data);
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (done === 1'b1) begin
      if (doneq.size() == 0) chk("unexpected_done", 64'(cyc), 64'hDEAD);
      else chk("done_cycle", 64'(cyc), 64'(doneq.pop_front()));
    end
    if (rst === 1'b1)
      chk("busy", 64'(busy), 64'(cyc >= busy_first && cyc <= busy_last));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse and record everything the job should produce.
  task automatic issue(input int l, input logic [31:0] s);
    int c0, dc;
    c0 = cyc;
    start = 1'b1;
    len = AW'(l);
    sum_in = s;
    for (int i = 0; i < l; i++) begin
      rdq.push_back('{cyc: c0 + 1 + i, addr: i, data: 32'd0});
      wrq.push_back('{cyc: c0 + 4 + i + LAT, addr: i,
                      data: (dir_exp.size() > i) ? dir_exp[i] : fdiv(mem[i], s)});
    end
    dir_exp.delete();
    dc = (l == 0) ? c0 + 2 : c0 + l + LAT + 4;
    doneq.push_back(dc);
    busy_first = c0 + 1;
    busy_last  = dc;
    $display("job start cycle %0d len %0d sum %08h", c0, l, s);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("done_timeout", 64'(n), 64'd0);
    tick();
  endtask

  task automatic check_reset();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd_en", 64'(rd_en), 0);
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_rd_addr", 64'(rd_addr), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_div_a", 64'(div_a), 0);
    chk("rst_div_b", 64'(div_b), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = rand_float();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h3F800000;
    for (int k = 0; k < LAT; k++) dpipe[k] = 32'd0;
    rst = 1'b0;
    repeat (3) tick();
    check_reset();
    rst = 1'b1;
    tick();

    // Directed job with known quotients.
    mem[0] = 32'h3F800000; mem[1] = 32'h40000000;
    mem[2] = 32'h40800000; mem[3] = 32'h41000000;
    dir_exp = '{32'h3E800000, 32'h3F000000, 32'h3F800000, 32'h40000000};
    issue(4, 32'h40800000);
    wait_done();

    // Empty job.
    issue(0, rand_float());
    wait_done();

    // start during ISSUE is ignored.
    fill_random(8);
    issue(4, 32'h40000000);
    start = 1'b1; len = AW'(7); sum_in = 32'h41200000;
    tick();
    start = 1'b0;
    wait_done();

    // Reset in the middle of a job.
    fill_random(4);
    issue(4, rand_float());
    repeat (9) tick();
    rst = 1'b0;
    rdq.delete(); wrq.delete(); doneq.delete();
    busy_first = 1; busy_last = 0;
    tick();
    check_reset();
    tick();
    rst = 1'b1;
    repeat (25) tick();
    fill_random(5);
    issue(5, rand_float());
    wait_done();

    // Random jobs with random gaps.
    for (int j = 0; j < 6; j++) begin
      int l;
      l = $urandom_range(1, 40);
      fill_random(l);
      issue(l, rand_float());
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    // Back-to-back jobs.
    fill_random(3);
    issue(3, rand_float());
    wait_done();
    fill_random(3);
    issue(3, rand_float());
    wait_done();

    // Maximum length.
    fill_random(1023);
    issue(1023, rand_float());
    wait_done();

    repeat (5) tick();
    chk("rdq_left", 64'(rdq.size()), 0);
    chk("wrq_left", 64'(wrq.size()), 0);
    chk("doneq_left", 64'(doneq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
